// File: rtl/jtag_tap_responder_if.sv
// JTAG pin bundle between the simulation driver (master) and the device-side TAP (slave).
interface jtag_tap_responder_if;
  logic jtag_TCK;
  logic jtag_TMS;
  logic jtag_TDI;
  logic jtag_TRSTn;
  logic jtag_TDO_data;
  logic jtag_TDO_driven;

  modport master (
    output jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn,
    input  jtag_TDO_data, jtag_TDO_driven
  );

  modport slave (
    input  jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn,
    output jtag_TDO_data, jtag_TDO_driven
  );
endinterface

// File: rtl/jtag_tap_responder.sv
// Device-side JTAG TAP with TCK oversampled in the system clock domain:
// 16-state TAP FSM, IR, IDCODE, BYPASS and one user data register.
module jtag_tap_responder #(
  parameter int                     IR_WIDTH     = 5,
  parameter logic [31:0]            IDCODE_VALUE = 32'h1000_0DB5,
  parameter logic [IR_WIDTH-1:0]    USER_INST    = 5'h11,
  parameter int                     USER_WIDTH   = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  jtag_tap_responder_if.slave       jtag,
  output logic [3:0]                tap_state,
  output logic [IR_WIDTH-1:0]       ir_value,
  input  logic [USER_WIDTH-1:0]     user_capture,
  output logic [USER_WIDTH-1:0]     user_dr,
  output logic                      user_update
);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1);
  // Bit order {TRSTn, TDI, TMS, TCK}; reset to the idle pin levels.
  localparam logic [3:0] SYNC_RESET = 4'b1010;

  logic [3:0] sync_s1_q, sync_s2_q;
  logic       tck_s3_q;
  logic       tck_s, tms_s, tdi_s, trstn_s, rise, fall;

  tap_state_e               state_q, state_d, tap_next;
  logic [IR_WIDTH-1:0]      ir_shift_q, ir_shift_d, ir_value_q, ir_value_d;
  logic [31:0]              idcode_shift_q, idcode_shift_d;
  logic [USER_WIDTH-1:0]    user_shift_q, user_shift_d, user_shifted;
  logic [USER_WIDTH-1:0]    user_dr_q, user_dr_d;
  logic                     bypass_q, bypass_d;
  logic                     user_update_q, user_update_d;
  logic                     tdo_data_q, tdo_data_d, tdo_driven_q, tdo_driven_d;
  logic                     sel_idcode, sel_user, dr_lsb;

  assign tck_s   = sync_s2_q[0];
  assign tms_s   = sync_s2_q[1];
  assign tdi_s   = sync_s2_q[2];
  assign trstn_s = sync_s2_q[3];
  assign rise    = tck_s & ~tck_s3_q;
  assign fall    = ~tck_s & tck_s3_q;

  assign sel_idcode = (ir_value_q == IR_IDCODE);
  assign sel_user   = !sel_idcode && (ir_value_q == USER_INST);
  assign dr_lsb     = sel_idcode ? idcode_shift_q[0] :
                      sel_user   ? user_shift_q[0]   : bypass_q;

  generate
    if (USER_WIDTH > 1) begin : g_user_wide
      assign user_shifted = {tdi_s, user_shift_q[USER_WIDTH-1:1]};
    end else begin : g_user_bit
      assign user_shifted = tdi_s;
    end
  endgenerate

  always_comb begin
    tap_next = state_q;
    case (state_q)
      TLR:      tap_next = tms_s ? TLR      : RTI;
      RTI:      tap_next = tms_s ? SEL_DR   : RTI;
      SEL_DR:   tap_next = tms_s ? SEL_IR   : CAP_DR;
      CAP_DR:   tap_next = tms_s ? EX1_DR   : SH_DR;
      SH_DR:    tap_next = tms_s ? EX1_DR   : SH_DR;
      EX1_DR:   tap_next = tms_s ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: tap_next = tms_s ? EX2_DR   : PAUSE_DR;
      EX2_DR:   tap_next = tms_s ? UPD_DR   : SH_DR;
      UPD_DR:   tap_next = tms_s ? SEL_DR   : RTI;
      SEL_IR:   tap_next = tms_s ? TLR      : CAP_IR;
      CAP_IR:   tap_next = tms_s ? EX1_IR   : SH_IR;
      SH_IR:    tap_next = tms_s ? EX1_IR   : SH_IR;
      EX1_IR:   tap_next = tms_s ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: tap_next = tms_s ? EX2_IR   : PAUSE_IR;
      EX2_IR:   tap_next = tms_s ? UPD_IR   : SH_IR;
      UPD_IR:   tap_next = tms_s ? SEL_DR   : RTI;
      default:  tap_next = TLR;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    ir_shift_d     = ir_shift_q;
    ir_value_d     = ir_value_q;
    idcode_shift_d = idcode_shift_q;
    user_shift_d   = user_shift_q;
    bypass_d       = bypass_q;
    user_dr_d      = user_dr_q;
    user_update_d  = 1'b0;
    tdo_data_d     = tdo_data_q;
    tdo_driven_d   = tdo_driven_q;

    // Test reset overrides TCK activity but leaves shift contents alone.
    if (!trstn_s) begin
      state_d = TLR;
    end else if (rise) begin
      state_d = tap_next;
      case (state_q)
        CAP_IR: ir_shift_d = IR_IDCODE;
        SH_IR:  ir_shift_d = {tdi_s, ir_shift_q[IR_WIDTH-1:1]};
        UPD_IR: ir_value_d = ir_shift_q;
        CAP_DR: begin
          if (sel_idcode)    idcode_shift_d = IDCODE_VALUE;
          else if (sel_user) user_shift_d   = user_capture;
          else               bypass_d       = 1'b0;
        end
        SH_DR: begin
          if (sel_idcode)    idcode_shift_d = {tdi_s, idcode_shift_q[31:1]};
          else if (sel_user) user_shift_d   = user_shifted;
          else               bypass_d       = tdi_s;
        end
        UPD_DR: begin
          if (sel_user) begin
            user_dr_d     = user_shift_q;
            user_update_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (state_d == TLR) ir_value_d = IR_IDCODE;

    if (fall) begin
      tdo_driven_d = (state_q == SH_IR) || (state_q == SH_DR);
      if (state_q == SH_IR)      tdo_data_d = ir_shift_q[0];
      else if (state_q == SH_DR) tdo_data_d = dr_lsb;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_s1_q      <= SYNC_RESET;
      sync_s2_q      <= SYNC_RESET;
      tck_s3_q       <= 1'b0;
      state_q        <= TLR;
      ir_shift_q     <= '0;
      ir_value_q     <= IR_IDCODE;
      idcode_shift_q <= '0;
      user_shift_q   <= '0;
      bypass_q       <= 1'b0;
      user_dr_q      <= '0;
      user_update_q  <= 1'b0;
      tdo_data_q     <= 1'b0;
      tdo_driven_q   <= 1'b0;
    end else begin
      sync_s1_q      <= {jtag.jtag_TRSTn, jtag.jtag_TDI, jtag.jtag_TMS, jtag.jtag_TCK};
      sync_s2_q      <= sync_s1_q;
      tck_s3_q       <= tck_s;
      state_q        <= state_d;
      ir_shift_q     <= ir_shift_d;
      ir_value_q     <= ir_value_d;
      idcode_shift_q <= idcode_shift_d;
      user_shift_q   <= user_shift_d;
      bypass_q       <= bypass_d;
      user_dr_q      <= user_dr_d;
      user_update_q  <= user_update_d;
      tdo_data_q     <= tdo_data_d;
      tdo_driven_q   <= tdo_driven_d;
    end
  end

  assign tap_state            = state_q;
  assign ir_value             = ir_value_q;
  assign user_dr              = user_dr_q;
  assign user_update          = user_update_q;
  assign jtag.jtag_TDO_data   = tdo_data_q;
  assign jtag.jtag_TDO_driven = tdo_driven_q;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench for jtag_tap_responder: table-driven TAP walk plus IDCODE,
// BYPASS, user DR, TMS-reset and TRSTn sequences.
module tb_jtag_tap_responder;
  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  tap_state;
  logic [4:0]  ir_value;
  logic [31:0] user_capture;
  logic [31:0] user_dr;
  logic        user_update;
  int          vec_cnt  = 0;
  int          miss_cnt = 0;
  int          pulse_cnt = 0;

  jtag_tap_responder_if jif ();

  jtag_tap_responder dut (
    .clock        (clock),
    .reset        (reset),
    .jtag         (jif),
    .tap_state    (tap_state),
    .ir_value     (ir_value),
    .user_capture (user_capture),
    .user_dr      (user_dr),
    .user_update  (user_update)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (user_update) pulse_cnt <= pulse_cnt + 1;

  typedef struct {
    logic       tms;
    logic [3:0] exp_state;
  } walk_vec_t;

  walk_vec_t walk [26] = '{
    '{1'b0, 4'd1},  '{1'b0, 4'd1},  '{1'b1, 4'd2},  '{1'b0, 4'd3},  '{1'b1, 4'd5},
    '{1'b0, 4'd6},  '{1'b0, 4'd6},  '{1'b1, 4'd7},  '{1'b0, 4'd4},  '{1'b1, 4'd5},
    '{1'b1, 4'd8},  '{1'b1, 4'd2},  '{1'b1, 4'd9},  '{1'b0, 4'd10}, '{1'b0, 4'd11},
    '{1'b1, 4'd12}, '{1'b0, 4'd13}, '{1'b1, 4'd14}, '{1'b0, 4'd11}, '{1'b1, 4'd12},
    '{1'b1, 4'd15}, '{1'b0, 4'd1},  '{1'b1, 4'd2},  '{1'b1, 4'd9},  '{1'b1, 4'd0},
    '{1'b1, 4'd0}
  };

  task automatic clks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // One TCK period; TDO is sampled just before the rise, as the driver does.
  task automatic tck_step(input logic tms, input logic tdi, output logic tdo, output logic drv);
    jif.jtag_TMS = tms;
    jif.jtag_TDI = tdi;
    clks(4);
    tdo = jif.jtag_TDO_data;
    drv = jif.jtag_TDO_driven;
    jif.jtag_TCK = 1'b1;
    clks(4);
    jif.jtag_TCK = 1'b0;
  endtask

  task automatic step(input logic tms);
    logic t, d;
    tck_step(tms, 1'b0, t, d);
  endtask

  // Shift n bits LSB-first, raising TMS on the last one to exit the shift state.
  task automatic shift_bits(input logic [31:0] din, input int n,
                            output logic [31:0] dout, output int undriven);
    logic t, d;
    dout = '0;
    undriven = 0;
    for (int i = 0; i < n; i++) begin
      tck_step(i == n - 1, din[i], t, d);
      dout[i] = t;
      if (!d) undriven++;
    end
  endtask

  initial begin
    logic [31:0] dout;
    int          undriven;
    int          base;
    logic        t, d;

    reset            = 1'b1;
    user_capture     = 32'h0;
    jif.jtag_TCK     = 1'b0;
    jif.jtag_TMS     = 1'b1;
    jif.jtag_TDI     = 1'b0;
    jif.jtag_TRSTn   = 1'b1;
    clks(2);
    reset = 1'b0;
    clks(1);
    check("reset_state",  32'(tap_state), 32'h0);
    check("reset_ir",     32'(ir_value), 32'h01);
    check("reset_driven", 32'(jif.jtag_TDO_driven), 32'h0);
    check("reset_tdo",    32'(jif.jtag_TDO_data), 32'h0);
    check("reset_userdr", user_dr, 32'h0);

    for (int i = 0; i < 26; i++) begin
      step(walk[i].tms);
      check($sformatf("walk[%0d]", i), 32'(tap_state), 32'(walk[i].exp_state));
    end
    check("walk_ir_tlr", 32'(ir_value), 32'h01);

    // IDCODE read
    step(1'b0); step(1'b1); step(1'b0);
    tck_step(1'b0, 1'b0, t, d);
    check("idcode_pre_drv", 32'(d), 32'h0);
    shift_bits(32'h0, 32, dout, undriven);
    check("idcode_value", dout, 32'h1000_0DB5);
    check("idcode_undrv", 32'(undriven), 32'h0);
    tck_step(1'b1, 1'b0, t, d);
    check("idcode_post_drv", 32'(d), 32'h0);
    step(1'b0);

    // IR capture then BYPASS
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    check("shir_state", 32'(tap_state), 32'd11);
    shift_bits(32'h1F, 5, dout, undriven);
    check("ir_capture_out", dout, 32'h01);
    step(1'b1); step(1'b0);
    check("ir_bypass", 32'(ir_value), 32'h1F);
    step(1'b1); step(1'b0); step(1'b0);
    shift_bits(32'b01101, 5, dout, undriven);
    check("bypass_out", dout, 32'h1A);
    step(1'b1); step(1'b0);

    // TMS reset from Pause-DR
    step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    check("pausedr_state", 32'(tap_state), 32'd6);
    base = pulse_cnt;
    repeat (5) step(1'b1);
    clks(2);
    check("tmsrst_state", 32'(tap_state), 32'h0);
    check("tmsrst_ir", 32'(ir_value), 32'h01);
    check("tmsrst_pulse", 32'(pulse_cnt - base), 32'h0);

    // User DR
    step(1'b0); step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    shift_bits(32'h11, 5, dout, undriven);
    step(1'b1); step(1'b0);
    check("ir_user", 32'(ir_value), 32'h11);
    user_capture = 32'hCAFE_F00D;
    step(1'b1); step(1'b0); step(1'b0);
    shift_bits(32'h1234_5678, 32, dout, undriven);
    check("user_shift_out", dout, 32'hCAFE_F00D);
    base = pulse_cnt;
    step(1'b1);
    check("user_dr_before_upd", user_dr, 32'h0);
    step(1'b0);
    clks(2);
    check("user_dr", user_dr, 32'h1234_5678);
    check("user_pulse", 32'(pulse_cnt - base), 32'h1);

    // TRSTn mid-shift
    step(1'b1); step(1'b0); step(1'b0);
    for (int i = 0; i < 4; i++) tck_step(1'b0, 1'b1, t, d);
    check("trst_pre_state", 32'(tap_state), 32'd4);
    base = pulse_cnt;
    jif.jtag_TRSTn = 1'b0;
    clks(3);
    check("trst_state", 32'(tap_state), 32'h0);
    check("trst_ir", 32'(ir_value), 32'h01);
    jif.jtag_TCK = 1'b1;
    clks(4);
    jif.jtag_TCK = 1'b0;
    clks(4);
    check("trst_state_hold", 32'(tap_state), 32'h0);
    check("trst_driven", 32'(jif.jtag_TDO_driven), 32'h0);
    check("trst_userdr", user_dr, 32'h1234_5678);
    check("trst_pulse", 32'(pulse_cnt - base), 32'h0);
    jif.jtag_TRSTn = 1'b1;
    clks(4);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
